// File: rtl/multi_digit_select.sv
// Multi-digit hex entry: cursor over DIGITS nibbles, up/down edit with
// auto-repeat, per-digit 7-segment decode.

// Hex nibble to 7-segment code, bit order {dp,g,f,e,d,c,b,a}, active high.
module seven_segments_hex (
   input  logic [3:0] digit,
   output logic [7:0] segments
);

   // Pure lookup of the glyph for one nibble
   always_comb begin
      segments = 8'h00;
      case (digit)
         4'h0: segments = 8'h3F;
         4'h1: segments = 8'h06;
         4'h2: segments = 8'h5B;
         4'h3: segments = 8'h4F;
         4'h4: segments = 8'h66;
         4'h5: segments = 8'h6D;
         4'h6: segments = 8'h7D;
         4'h7: segments = 8'h07;
         4'h8: segments = 8'h7F;
         4'h9: segments = 8'h6F;
         4'hA: segments = 8'h77;
         4'hB: segments = 8'h7C;
         4'hC: segments = 8'h39;
         4'hD: segments = 8'h5E;
         4'hE: segments = 8'h79;
         4'hF: segments = 8'h71;
         default: segments = 8'h00;
      endcase
   end

endmodule

// Press detection plus hold/repeat timing for one level key.
module multi_digit_select_repeat #(
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic fire
);

   localparam int MAX_COUNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW        = $clog2(MAX_COUNT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HOLDING = 2'd1;
   localparam logic [1:0] REPEAT  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;
   logic          key_prev;
   logic          press;

   assign press     = key & ~key_prev;
   assign count_inc = count + CW'(1);

   // Event on the press edge, on reaching the hold length, and every repeat period after
   always_comb begin
      fire = press;
      if (key && !press) begin
         if (state == HOLDING && count_inc == CW'(HOLD_CYCLES))
            fire = 1'b1;
         if (state == REPEAT && count_inc == CW'(REPEAT_CYCLES))
            fire = 1'b1;
      end
   end

   // Counting only starts from a genuine press, so a key held through reset stays inert
   always_ff @(posedge clock) begin
      if (reset) begin
         key_prev <= 1'b1;
         state    <= IDLE;
         count    <= '0;
      end else begin
         key_prev <= key;
         if (!key) begin
            state <= IDLE;
            count <= '0;
         end else if (press) begin
            state <= HOLDING;
            count <= CW'(1);
         end else begin
            case (state)
               HOLDING: begin
                  if (count_inc == CW'(HOLD_CYCLES)) begin
                     state <= REPEAT;
                     count <= '0;
                  end else begin
                     count <= count_inc;
                  end
               end
               REPEAT: begin
                  if (count_inc == CW'(REPEAT_CYCLES))
                     count <= '0;
                  else
                     count <= count_inc;
               end
               default: begin
                  state <= state;
                  count <= count;
               end
            endcase
         end
      end
   end

endmodule

module multi_digit_select #(
   parameter int DIGITS        = 4,
   parameter int CARRY         = 0,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   localparam int CURSOR_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  up_key,
   input  logic                  down_key,
   input  logic                  left_key,
   input  logic                  right_key,
   output logic [8*DIGITS-1:0]   display,
   output logic [4*DIGITS-1:0]   hex_value,
   output logic [CURSOR_W-1:0]   cursor,
   output logic [DIGITS-1:0]     cursor_onehot
);

   localparam int VW = 4 * DIGITS;

   logic                up_fire;
   logic                down_fire;
   logic                left_prev;
   logic                right_prev;
   logic                left_press;
   logic                right_press;
   logic [VW-1:0]       step;
   logic [VW-1:0]       nibble_mask;
   logic [VW-1:0]       sum;
   logic [VW-1:0]       edited;
   logic [CURSOR_W-1:0] cursor_next;

   multi_digit_select_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_up_repeat (
      .clock (clock),
      .reset (reset),
      .key   (up_key),
      .fire  (up_fire)
   );

   multi_digit_select_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_down_repeat (
      .clock (clock),
      .reset (reset),
      .key   (down_key),
      .fire  (down_fire)
   );

   assign left_press  = left_key & ~left_prev;
   assign right_press = right_key & ~right_prev;

   // One adder serves both modes: without carry, only the selected nibble of the sum is kept
   always_comb begin
      step        = VW'(1) << {cursor, 2'b00};
      nibble_mask = VW'(4'hF) << {cursor, 2'b00};
      sum         = up_fire ? (hex_value + step) : (hex_value - step);
      if (CARRY != 0)
         edited = sum;
      else
         edited = (sum & nibble_mask) | (hex_value & ~nibble_mask);
   end

   // Saturating cursor move; opposite presses in one cycle cancel
   always_comb begin
      cursor_next = cursor;
      if (left_press && !right_press && cursor != CURSOR_W'(DIGITS - 1))
         cursor_next = cursor + CURSOR_W'(1);
      else if (right_press && !left_press && cursor != '0)
         cursor_next = cursor - CURSOR_W'(1);
   end

   // Value and cursor registers; edit uses the pre-move cursor
   always_ff @(posedge clock) begin
      if (reset) begin
         hex_value  <= '0;
         cursor     <= '0;
         left_prev  <= 1'b1;
         right_prev <= 1'b1;
      end else begin
         left_prev  <= left_key;
         right_prev <= right_key;
         if (up_fire || down_fire)
            hex_value <= edited;
         cursor <= cursor_next;
      end
   end

   assign cursor_onehot = DIGITS'(1) << cursor;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      seven_segments_hex u_seg (
         .digit    (hex_value[4*i +: 4]),
         .segments (display[8*i +: 8])
      );
   end

endmodule

// File: tb/tb_multi_digit_select.sv
// Scoreboard bench: two DUTs (CARRY=0 and CARRY=1) share stimulus; a
// behavioural model queues expected state, a monitor pops and compares.
module tb_multi_digit_select;

   localparam int D = 4;
   localparam int H = 8;
   localparam int R = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        up_key = 1'b0;
   logic        down_key = 1'b0;
   logic        left_key = 1'b0;
   logic        right_key = 1'b0;
   logic [31:0] display0, display1;
   logic [15:0] hex0, hex1;
   logic [1:0]  cur0, cur1;
   logic [3:0]  oh0, oh1;

   always #5 clock = ~clock;

   multi_digit_select #(.DIGITS(D), .CARRY(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut0 (
      .clock(clock), .reset(reset), .up_key(up_key), .down_key(down_key),
      .left_key(left_key), .right_key(right_key), .display(display0),
      .hex_value(hex0), .cursor(cur0), .cursor_onehot(oh0));

   multi_digit_select #(.DIGITS(D), .CARRY(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut1 (
      .clock(clock), .reset(reset), .up_key(up_key), .down_key(down_key),
      .left_key(left_key), .right_key(right_key), .display(display1),
      .hex_value(hex1), .cursor(cur1), .cursor_onehot(oh1));

   typedef struct {
      logic [15:0] v0;
      logic [15:0] v1;
      int unsigned cur;
   } exp_t;

   exp_t sb[$];

   int unsigned checks = 0;
   int unsigned errors = 0;

   // model state
   logic [15:0] m_v0, m_v1;
   int unsigned m_cur;
   bit          p_u, p_d, p_l, p_r;
   int unsigned n_u, n_d;

   function automatic logic [7:0] seg(input logic [3:0] n);
      logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      return tbl[n];
   endfunction

   function automatic logic [31:0] disp(input logic [15:0] v);
      logic [31:0] d;
      for (int i = 0; i < 4; i++) d[8*i +: 8] = seg(v[4*i +: 4]);
      return d;
   endfunction

   // key held for n edges (press edge is n=1) -> does it produce an event now
   function automatic bit fires(input int unsigned n);
      return (n == 1) || (n >= H && ((n - H) % R) == 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic edit(input bit inc);
      int unsigned sh;
      sh = 4 * m_cur;
      if (inc) begin
         m_v0[sh +: 4] = m_v0[sh +: 4] + 4'd1;
         m_v1 = m_v1 + (16'd1 << sh);
      end else begin
         m_v0[sh +: 4] = m_v0[sh +: 4] - 4'd1;
         m_v1 = m_v1 - (16'd1 << sh);
      end
   endtask

   // one clock: drive inputs, advance model, queue expectation, return after the edge
   task automatic cyc(input bit rst, input bit u, input bit d, input bit l, input bit r);
      bit fu, fd, lp, rp;
      exp_t e;
      @(negedge clock);
      reset = rst; up_key = u; down_key = d; left_key = l; right_key = r;
      if (rst) begin
         m_v0 = '0; m_v1 = '0; m_cur = 0;
         p_u = 1; p_d = 1; p_l = 1; p_r = 1;
         n_u = 0; n_d = 0;
      end else begin
         n_u = !u ? 0 : (!p_u ? 1 : (n_u > 0 ? n_u + 1 : 0));
         n_d = !d ? 0 : (!p_d ? 1 : (n_d > 0 ? n_d + 1 : 0));
         fu = (n_u > 0) && fires(n_u);
         fd = (n_d > 0) && fires(n_d);
         lp = l && !p_l;
         rp = r && !p_r;
         if (fu) edit(1'b1);
         else if (fd) edit(1'b0);
         if (lp && !rp && m_cur < D - 1) m_cur++;
         else if (rp && !lp && m_cur > 0) m_cur--;
         p_u = u; p_d = d; p_l = l; p_r = r;
      end
      e.v0 = m_v0; e.v1 = m_v1; e.cur = m_cur;
      sb.push_back(e);
      @(posedge clock);
      #2;
   endtask

   task automatic pulse(input bit u, input bit d, input bit l, input bit r);
      cyc(0, u, d, l, r);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   // monitor: compare DUT state after every edge that has a queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hex_c0", 32'(hex0), 32'(e.v0));
            chk("hex_c1", 32'(hex1), 32'(e.v1));
            chk("disp_c0", display0, disp(e.v0));
            chk("disp_c1", display1, disp(e.v1));
            chk("cursor", 32'(cur0), e.cur);
            chk("cursor_c1", 32'(cur1), e.cur);
            chk("onehot", 32'(oh0), 32'(1) << e.cur);
            chk("onehot_c1", 32'(oh1), 32'(1) << e.cur);
         end
      end
   end

   initial begin
      bit ru, rd, rl, rr, rs;

      // reset with up held, no event after release of reset
      repeat (3) cyc(1, 1, 0, 0, 0);
      chk("rst_hex", 32'(hex0), 32'h0);
      chk("rst_onehot", 32'(oh0), 32'h1);
      chk("rst_disp", display0, 32'h3F3F3F3F);
      repeat (12) cyc(0, 1, 0, 0, 0);
      chk("held_thru_rst", 32'(hex0), 32'h0);
      pulse(0, 0, 0, 0);
      pulse(1, 0, 0, 0);
      chk("first_press", 32'(hex0), 32'h0001);

      // nibble wrap vs carry
      do_reset();
      pulse(0, 1, 0, 0);
      chk("c0_down_wrap", 32'(hex0), 32'h000F);
      chk("c1_down_borrow", 32'(hex1), 32'hFFFF);
      pulse(1, 0, 0, 0);
      chk("c0_F_plus1", 32'(hex0), 32'h0000);
      pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      chk("c0_dig1_down", 32'(hex0), 32'h00F0);
      chk("c1_dig1_down", 32'(hex1), 32'hFFF0);

      do_reset();
      repeat (5) pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      chk("c1_0005_down", 32'(hex1), 32'hFFF5);
      do_reset();
      repeat (5) pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      repeat (15) pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      chk("c1_00F5_up", 32'(hex1), 32'h0105);
      chk("c0_00F5_up", 32'(hex0), 32'h0005);

      // auto-repeat
      do_reset();
      repeat (20) cyc(0, 1, 0, 0, 0);
      chk("hold20", 32'(hex0), 32'h0005);
      cyc(0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("down3", 32'(hex0), 32'h0004);

      // cursor
      do_reset();
      repeat (5) pulse(0, 0, 1, 0);
      chk("cur_sat", 32'(cur0), 32'd3);
      chk("onehot_sat", 32'(oh0), 32'b1000);
      pulse(0, 0, 0, 1);
      pulse(0, 0, 1, 1);
      chk("lr_cancel", 32'(cur0), 32'd2);
      repeat (4) pulse(0, 0, 0, 1);
      chk("cur_floor", 32'(cur0), 32'd0);
      do_reset();
      repeat (2) pulse(0, 0, 1, 0);
      pulse(1, 0, 1, 0);
      chk("edit_move_val", 32'(hex0), 32'h0100);
      chk("edit_move_cur", 32'(cur0), 32'd3);

      // up+down same cycle, reset mid-hold
      do_reset();
      pulse(1, 1, 0, 0);
      chk("up_wins", 32'(hex0), 32'h0001);
      do_reset();
      repeat (9) cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (15) cyc(0, 1, 0, 0, 0);
      chk("rst_midhold", 32'(hex0), 32'h0000);
      cyc(0, 0, 0, 0, 0);

      // randomized phase
      ru = 0; rd = 0; rl = 0; rr = 0;
      for (int i = 0; i < 600; i++) begin
         rs = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 9) == 0) ru = ~ru;
         if ($urandom_range(0, 9) == 0) rd = ~rd;
         if ($urandom_range(0, 5) == 0) rl = ~rl;
         if ($urandom_range(0, 5) == 0) rr = ~rr;
         cyc(rs, ru, rd, rl, rr);
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
